// File: rtl/fifo_wr_gen.sv
// FIFO write-side traffic generator: waits for the FIFO to drain, then writes a data
// pattern until almost-full or a burst limit. Define FIFO_WR_GEN_LFSR_EN to build mode 2 as an LFSR.
module fifo_wr_gen #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_VAL     = 254,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BURST_LEN   = 0,
  parameter int unsigned CNT_W       = 16
`ifdef FIFO_WR_GEN_LFSR_EN
  ,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic              empty,
  input  logic              almost_full,
  input  logic              wr_rst_busy,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              burst_done,
  output logic              busy
);

  localparam int unsigned SESS_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_EMPTY = 2'd1,
    WRITE      = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   empty_sync_q;
  logic [1:0]               mode_q, mode_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [SESS_W-1:0]        sess_q, sess_d;
  logic                     wr_en_q, wr_en_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     burst_done_q, burst_done_d;
  logic                     busy_q, busy_d;
  logic                     burst_last;

  // First word of a session for the selected pattern
  function automatic logic [DATA_W-1:0] seed_f(input logic [1:0] m,
                                               input logic [DATA_W-1:0] p);
    logic [DATA_W-1:0] r;
    r = '0;
    case (m)
      2'd1: r = p;
      2'd3: r = DATA_W'(1);
`ifdef FIFO_WR_GEN_LFSR_EN
      2'd2: r = DATA_W'(1);
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Word following v for the selected pattern
  function automatic logic [DATA_W-1:0] advance_f(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    case (m)
      2'd1: r = v;
      2'd3: r = {v[DATA_W-2:0], v[DATA_W-1]};
`ifdef FIFO_WR_GEN_LFSR_EN
      2'd2: r = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
`endif
      default: r = (v >= DATA_W'(MAX_VAL)) ? '0 : v + DATA_W'(1);
    endcase
    return r;
  endfunction

  assign burst_last = (BURST_LEN != 0) && (sess_q == SESS_W'(BURST_LEN - 1));

  // Next-state, data sequencing and registered-output precompute
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    data_d       = data_q;
    sess_d       = sess_q;
    wr_en_d      = 1'b0;
    cnt_d        = cnt_q;
    burst_done_d = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      IDLE:       if (enable && !wr_rst_busy) state_d = WAIT_EMPTY;
      WAIT_EMPTY: if (empty_sync_q[SYNC_STAGES-1]) state_d = WRITE;
      WRITE: begin
        if (wr_en_q && burst_last) state_d = DONE;
        else if (almost_full)      state_d = WAIT_EMPTY;
      end
      DONE:       state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (!enable || wr_rst_busy) state_d = IDLE;

    if (state_q == IDLE && state_d == WAIT_EMPTY) begin
      mode_d = mode;
      data_d = seed_f(mode, pattern);
      sess_d = '0;
    end else if (wr_en_q) begin
      data_d = advance_f(mode_q, data_q);
      sess_d = sess_q + SESS_W'(1);
    end

    // The strobe trails the state by one edge and drops on any exit from WRITE
    wr_en_d      = (state_q == WRITE) && (state_d == WRITE);
    cnt_d        = cnt_q + CNT_W'(wr_en_q);
    burst_done_d = (state_d == DONE) && (state_q != DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      empty_sync_q <= '0;
      mode_q       <= '0;
      data_q       <= '0;
      sess_q       <= '0;
      wr_en_q      <= 1'b0;
      cnt_q        <= '0;
      burst_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      empty_sync_q <= {empty_sync_q[SYNC_STAGES-2:0], empty};
      mode_q       <= mode_d;
      data_q       <= data_d;
      sess_q       <= sess_d;
      wr_en_q      <= wr_en_d;
      cnt_q        <= cnt_d;
      burst_done_q <= burst_done_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = data_q;
  assign wr_cnt       = cnt_q;
  assign burst_done   = burst_done_q;
  assign busy         = busy_q;

endmodule
